poly_note_player: RTL and testbench

Multi-voice successor to the single-voice note player. It holds VOICES independent voices, each with its own phase accumulator, duration counter and waveform mode. Voices advance on sampling_pulse and count down on beat, and are mixed into one signed sample stream. It sits between the song sequencer, which loads notes and reacts to note_done, and the codec/sample sink, which consumes sample on sample_ready.

---
 rtl/poly_note_player.sv | 124 ++++++++++++
 tb/tb_poly_note_player.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/poly_note_player.sv
// Multi-voice note player: per-voice phase/duration/waveform state, mixed into
// one signed sample stream through a two-stage pipeline behind sampling_pulse.
module poly_note_player #(
  parameter int VOICES   = 4,
  parameter int PHASE_W  = 20,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16,
  localparam int VW      = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int SHIFT   = $clog2(VOICES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                load_new_note,
  input  logic [VW-1:0]       load_voice,
  input  logic [PHASE_W-1:0]  step_to_load,
  input  logic [DUR_W-1:0]    duration_to_load,
  input  logic [1:0]          wave_to_load,
  input  logic                beat,
  input  logic                sampling_pulse,
  output logic [VOICES-1:0]   note_done,
  output logic [VOICES-1:0]   voice_active,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_ready
);

  localparam logic [SAMPLE_W-1:0] W_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] W_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

  logic [PHASE_W-1:0]         r_phase [VOICES];
  logic [PHASE_W-1:0]         r_step  [VOICES];
  logic [DUR_W-1:0]           r_dur   [VOICES];
  logic [1:0]                 r_wave  [VOICES];
  logic [VOICES-1:0]          r_active;
  logic [VOICES-1:0]          r_note_done;
  logic signed [SAMPLE_W-1:0] r_val   [VOICES];
  logic                       r_s0_valid;
  logic                       r_s1_valid;
  logic [SAMPLE_W-1:0]        r_sample;
  logic                       r_sample_ready;

  logic [SAMPLE_W-1:0]        w_wave  [VOICES];
  logic signed [SAMPLE_W-1:0] w_sum;

  // Waveform shaping from the top SAMPLE_W bits of each phase accumulator.
  for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
    logic [SAMPLE_W-1:0] w_p;
    logic [SAMPLE_W-1:0] w_t;
    assign w_p = r_phase[gi][PHASE_W-1 -: SAMPLE_W];
    assign w_t = w_p[SAMPLE_W-1] ? ~(w_p << 1) : (w_p << 1);
    assign w_wave[gi] =
      (r_wave[gi] == 2'd0) ? (w_p[SAMPLE_W-1] ? W_NEG : W_POS) :
      (r_wave[gi] == 2'd1) ? {~w_p[SAMPLE_W-1], w_p[SAMPLE_W-2:0]} :
      (r_wave[gi] == 2'd2) ? {~w_t[SAMPLE_W-1], w_t[SAMPLE_W-2:0]} :
                             '0;
  end

  // Pre-scaling each voice by 1/VOICES keeps the sum inside SAMPLE_W bits.
  always_comb begin
    w_sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      w_sum = w_sum + (r_val[v] >>> SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < VOICES; v++) begin
        r_phase[v] <= '0;
        r_step[v]  <= '0;
        r_dur[v]   <= '0;
        r_wave[v]  <= '0;
        r_val[v]   <= '0;
      end
      r_active       <= '0;
      r_note_done    <= '0;
      r_s0_valid     <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_sample       <= '0;
      r_sample_ready <= 1'b0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        r_note_done[v] <= 1'b0;
        // A load on this voice overrides any beat or pulse on the same edge.
        if (load_new_note && (int'(load_voice) == v)) begin
          r_phase[v]     <= '0;
          r_step[v]      <= step_to_load;
          r_wave[v]      <= wave_to_load;
          r_dur[v]       <= duration_to_load;
          r_active[v]    <= (duration_to_load != '0);
          r_note_done[v] <= (duration_to_load == '0);
        end else if (play_enable && r_active[v]) begin
          if (sampling_pulse) begin
            r_phase[v] <= r_phase[v] + r_step[v];
          end
          if (beat) begin
            r_dur[v] <= r_dur[v] - DUR_W'(1);
            if (r_dur[v] == DUR_W'(1)) begin
              r_active[v]    <= 1'b0;
              r_note_done[v] <= 1'b1;
            end
          end
        end
        if (r_s0_valid) begin
          r_val[v] <= r_active[v] ? w_wave[v] : '0;
        end
      end

      // Pipeline stages run regardless of play_enable so in-flight samples finish.
      r_s0_valid     <= play_enable && sampling_pulse;
      r_s1_valid     <= r_s0_valid;
      r_sample_ready <= r_s1_valid;
      if (r_s1_valid) begin
        r_sample <= w_sum;
      end
    end
  end

  assign note_done    = r_note_done;
  assign voice_active = r_active;
  assign sample       = r_sample;
  assign sample_ready = r_sample_ready;

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player: loads, beats, sample pipeline, pause, reset.
module tb_poly_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        load_new_note;
  logic [1:0]  load_voice;
  logic [19:0] step_to_load;
  logic [5:0]  duration_to_load;
  logic [1:0]  wave_to_load;
  logic        beat;
  logic        sampling_pulse;
  logic [3:0]  note_done;
  logic [3:0]  voice_active;
  logic [15:0] sample;
  logic        sample_ready;

  int total = 0;
  int bad   = 0;

  poly_note_player dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .load_new_note    (load_new_note),
    .load_voice       (load_voice),
    .step_to_load     (step_to_load),
    .duration_to_load (duration_to_load),
    .wave_to_load     (wave_to_load),
    .beat             (beat),
    .sampling_pulse   (sampling_pulse),
    .note_done        (note_done),
    .voice_active     (voice_active),
    .sample           (sample),
    .sample_ready     (sample_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s val=%0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int v, input int stp, input int dur, input int wv);
    load_new_note    = 1'b1;
    load_voice       = 2'(v);
    step_to_load     = 20'(stp);
    duration_to_load = 6'(dur);
    wave_to_load     = 2'(wv);
    tick(1);
    load_new_note    = 1'b0;
  endtask

  task automatic pulse();
    sampling_pulse = 1'b1;
    tick(1);
    sampling_pulse = 1'b0;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
  endtask

  // Issue one pulse and check the sample that appears two edges later.
  task automatic sample_check(input string tag, input int exp);
    pulse();
    tick(2);
    check(tag, $signed(sample), exp);
  endtask

  initial begin
    int ready_cnt;
    reset = 1'b0; play_enable = 1'b0; load_new_note = 1'b0; load_voice = '0;
    step_to_load = '0; duration_to_load = '0; wave_to_load = '0;
    beat = 1'b0; sampling_pulse = 1'b0;
    tick(3);
    check("rst_sample", $signed(sample), 0);
    check("rst_ready", int'(sample_ready), 0);
    check("rst_active", int'(voice_active), 0);
    check("rst_done", int'(note_done), 0);
    reset = 1'b1;
    tick(1);

    // 1: square voice, latency and level
    play_enable = 1'b1;
    load(0, 'h10000, 10, 0);
    check("t1_active", int'(voice_active), 1);
    pulse();
    check("t1_rdy_e0", int'(sample_ready), 0);
    tick(1);
    check("t1_rdy_e1", int'(sample_ready), 0);
    tick(1);
    check("t1_rdy_e2", int'(sample_ready), 1);
    check("t1_sample1", $signed(sample), 8191);
    tick(1);
    check("t1_rdy_e3", int'(sample_ready), 0);
    check("t1_hold", $signed(sample), 8191);
    for (int i = 0; i < 7; i++) pulse();
    tick(2);
    check("t1_sample8", $signed(sample), -8192);

    // 2: duration expiry on voice1
    load(1, 0, 3, 0);
    check("t2_active", int'(voice_active), 3);
    do_beat();
    check("t2_done_b1", int'(note_done), 0);
    do_beat();
    do_beat();
    check("t2_done_b3", int'(note_done), 2);
    check("t2_active_b3", int'(voice_active), 1);
    tick(1);
    check("t2_done_clr", int'(note_done), 0);

    // 3: full-scale four-voice mix
    for (int v = 0; v < 4; v++) load(v, 'h80000, 20, 0);
    check("t3_active", int'(voice_active), 15);
    sample_check("t3_neg", -32768);
    sample_check("t3_pos", 32764);

    // 4: saw wrap; zero-duration loads silence the other voices
    load(0, 'h80000, 20, 1);
    load(1, 0, 0, 0);
    check("t4_zdone", int'(note_done), 2);
    check("t4_zactive", int'(voice_active), 13);
    load(2, 0, 0, 0);
    load(3, 0, 0, 0);
    check("t4_active", int'(voice_active), 1);
    sample_check("t4_s1", 0);
    sample_check("t4_s2", -8192);
    sample_check("t4_s3", 0);

    // 5: load beats a simultaneous beat on the same voice
    load(2, 0, 1, 0);
    load_new_note = 1'b1; load_voice = 2'd2; duration_to_load = 6'd5;
    step_to_load = '0; wave_to_load = 2'd0; beat = 1'b1;
    tick(1);
    load_new_note = 1'b0; beat = 1'b0;
    check("t5_nodone", int'(note_done), 0);
    check("t5_active", int'(voice_active), 5);
    for (int i = 0; i < 4; i++) do_beat();
    check("t5_still", int'(voice_active), 5);
    do_beat();
    check("t5_done", int'(note_done), 4);

    // 6: pause freezes state, resume continues, reset kills voices
    load(1, 'h10000, 2, 0);
    check("t6_active", int'(voice_active), 3);
    play_enable = 1'b0;
    ready_cnt = 0;
    beat = 1'b1; sampling_pulse = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (sample_ready) ready_cnt++;
    end
    beat = 1'b0; sampling_pulse = 1'b0;
    check("t6_pause_rdy", ready_cnt, 0);
    check("t6_pause_act", int'(voice_active), 3);
    play_enable = 1'b1;
    sample_check("t6_resume", -1);
    do_beat();
    check("t6_b1", int'(note_done), 0);
    do_beat();
    check("t6_b2", int'(note_done), 2);
    load(3, 0, 1, 0);
    reset = 1'b0; beat = 1'b1;
    tick(1);
    beat = 1'b0;
    check("t6_rst_act", int'(voice_active), 0);
    check("t6_rst_done", int'(note_done), 0);
    check("t6_rst_smp", $signed(sample), 0);
    check("t6_rst_rdy", int'(sample_ready), 0);
    reset = 1'b1;
    tick(1);
    check("t6_post_done", int'(note_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
